// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states
// and the ALU / PC mux select codes used by the datapath and ALU control.
package mips_ctrl_pkg;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_LW    = 3'b001;
  localparam logic [2:0] OP_SW    = 3'b010;
  localparam logic [2:0] OP_BEQ   = 3'b011;
  localparam logic [2:0] OP_ADDI  = 3'b100;
  localparam logic [2:0] OP_J     = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_FUNCT = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_ADD   = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    SRCB_REG    = 2'b00,
    SRCB_INC    = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_BRANCH = 2'b11
  } srcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_e;

  typedef struct packed {
    logic   pc_write;
    logic   pc_write_cond;
    logic   i_or_d;
    logic   mem_read;
    logic   mem_write;
    logic   ir_write;
    logic   mem_to_reg;
    logic   reg_write;
    logic   reg_dst;
    logic   alu_src_a;
    srcb_e  alu_src_b;
    aluop_e alu_op;
    pcsrc_e pc_source;
    logic   instr_done;
    logic   illegal_op;
    logic   mem_timeout;
  } ctrl_t;

  // States that stall on the memory handshake.
  function automatic logic is_mem_wait(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Opcode / memory handshake inputs and datapath control outputs of the
// multicycle control unit; master drives the opcode side, slave is the FSM.
interface multicycle_control_unit_if #(
  parameter int OP_WIDTH = 3
);
  logic [OP_WIDTH-1:0] op;
  logic                mem_ready;
  logic                PCWrite;
  logic                PCWriteCond;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                IRWrite;
  logic                MemToReg;
  logic                RegWrite;
  logic                RegDst;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ALUOp;
  logic [1:0]          PCSource;
  logic                instr_done;
  logic                illegal_op;
  logic                mem_timeout;
  logic [3:0]          state;

  modport master (
    output op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done,
           illegal_op, mem_timeout, state
  );

  modport slave (
    input  op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done,
           illegal_op, mem_timeout, state
  );
endinterface

// File: rtl/multicycle_control_unit_wait_timer.sv
// Saturating wait counter: expired_o is high once LIMIT-1 enabled cycles have
// been counted, so the LIMIT-th enabled cycle sees it. LIMIT=0 disables it.
module wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  generate
    if (LIMIT == 0) begin : g_disabled
      assign expired_o = 1'b0;
    end else begin : g_count
      localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
      localparam logic [CW-1:0] MAX = CW'(LIMIT - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
          cnt_d = '0;
        end else if (en_i && (cnt_q != MAX)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expired_o = (cnt_q == MAX);
    end
  endgenerate

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back,
// stalls on mem_ready and aborts memory waits that exceed WAIT_LIMIT cycles.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int          OP_WIDTH   = 3,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_control_unit_if.slave    bus
);

  localparam logic [OP_WIDTH-1:0] C_RTYPE = OP_WIDTH'(OP_RTYPE);
  localparam logic [OP_WIDTH-1:0] C_LW    = OP_WIDTH'(OP_LW);
  localparam logic [OP_WIDTH-1:0] C_SW    = OP_WIDTH'(OP_SW);
  localparam logic [OP_WIDTH-1:0] C_BEQ   = OP_WIDTH'(OP_BEQ);
  localparam logic [OP_WIDTH-1:0] C_ADDI  = OP_WIDTH'(OP_ADDI);
  localparam logic [OP_WIDTH-1:0] C_J     = OP_WIDTH'(OP_J);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   op_legal;
  logic   stall;
  logic   expired;
  logic   timeout;
  logic   cnt_clr;

  assign op_legal = (bus.op == C_RTYPE) || (bus.op == C_LW) || (bus.op == C_SW) ||
                    (bus.op == C_BEQ) || (bus.op == C_ADDI) || (bus.op == C_J);

  assign stall   = is_mem_wait(state_q) && !bus.mem_ready;
  // mem_ready in the limit cycle completes the access instead of aborting.
  assign timeout = stall && expired;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if ((bus.op == C_LW) || (bus.op == C_SW)) state_d = S_MEM_ADDR;
        else if (bus.op == C_RTYPE)               state_d = S_EXEC;
        else if (bus.op == C_BEQ)                 state_d = S_BRANCH;
        else if (bus.op == C_J)                   state_d = S_JUMP;
        else if (bus.op == C_ADDI)                state_d = S_ADDI_EX;
        else                                      state_d = S_FETCH;
      end
      S_MEM_ADDR: state_d = (bus.op == C_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC:     state_d = S_ALU_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      default:    state_d = S_FETCH;
    endcase
    if (timeout) state_d = S_FETCH;
  end

  // A FETCH timeout loops FETCH->FETCH, so the count is also cleared on timeout.
  assign cnt_clr = (state_d != state_q) || timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  wait_timer #(
    .LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cnt_clr),
    .en_i      (stall),
    .expired_o (expired)
  );

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_INC;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_BRANCH;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = !op_legal;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = bus.mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
    ctrl.mem_timeout = timeout;
    // Reset silences every strobe immediately, not just after the next edge.
    if (!rst_n) ctrl = '0;
  end

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.i_or_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemToReg    = ctrl.mem_to_reg;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.instr_done  = ctrl.instr_done;
  assign bus.illegal_op  = ctrl.illegal_op;
  assign bus.mem_timeout = ctrl.mem_timeout;
  assign bus.state       = rst_n ? state_q : S_FETCH;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Cycle-by-cycle scoreboard bench for the multicycle control unit (WAIT_LIMIT=4).
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       done, ill, to;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [2:0] op;
    logic       mr;
    logic [3:0] st;
    logic       ill;
    logic       to;
  } cyc_t;

  typedef struct {
    logic [3:0] st;
    outs_t      o;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  cyc_t stim[$];
  exp_t sb[$];

  multicycle_control_unit_if #(.OP_WIDTH(3)) bus ();

  multicycle_control_unit #(
    .OP_WIDTH   (3),
    .WAIT_LIMIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected strobes per state, transcribed from the per-state output table.
  function automatic outs_t exp_outs(input logic [3:0] st, input logic mr, input logic ill,
                                     input logic to);
    outs_t o;
    o = '0;
    case (st)
      4'd0:         begin o.pcw = mr; o.irw = mr; o.mrd = 1'b1; o.srcb = 2'b01; o.aluop = 2'b11; end
      4'd1:         begin o.srcb = 2'b11; o.aluop = 2'b11; o.ill = ill; end
      4'd2, 4'd10:  begin o.srca = 1'b1; o.srcb = 2'b10; o.aluop = 2'b11; end
      4'd3:         begin o.mrd = 1'b1; o.iord = 1'b1; end
      4'd4:         begin o.rw = 1'b1; o.m2r = 1'b1; o.done = 1'b1; end
      4'd5:         begin o.mwr = 1'b1; o.iord = 1'b1; o.done = mr; end
      4'd6:         begin o.srca = 1'b1; end
      4'd7:         begin o.rw = 1'b1; o.rdst = 1'b1; o.done = 1'b1; end
      4'd8:         begin o.srca = 1'b1; o.aluop = 2'b01; o.pcwc = 1'b1; o.pcsrc = 2'b01; o.done = 1'b1; end
      4'd9:         begin o.pcw = 1'b1; o.pcsrc = 2'b10; o.done = 1'b1; end
      4'd11:        begin o.rw = 1'b1; o.done = 1'b1; end
      default:      o = '0;
    endcase
    o.to = to;
    return o;
  endfunction

  function automatic outs_t dut_outs();
    outs_t o;
    o.pcw = bus.PCWrite;   o.pcwc = bus.PCWriteCond; o.iord = bus.IorD;
    o.mrd = bus.MemRead;   o.mwr = bus.MemWrite;     o.irw = bus.IRWrite;
    o.m2r = bus.MemToReg;  o.rw = bus.RegWrite;      o.rdst = bus.RegDst;
    o.srca = bus.ALUSrcA;  o.srcb = bus.ALUSrcB;     o.aluop = bus.ALUOp;
    o.pcsrc = bus.PCSource; o.done = bus.instr_done; o.ill = bus.illegal_op;
    o.to = bus.mem_timeout;
    return o;
  endfunction

  task automatic add(input logic [2:0] op, input logic mr, input logic [3:0] st,
                     input logic ill = 1'b0, input logic to = 1'b0, input logic rst = 1'b1);
    cyc_t c;
    c.rst = rst; c.op = op; c.mr = mr; c.st = st; c.ill = ill; c.to = to;
    stim.push_back(c);
  endtask

  task automatic test_reset();
    exp_t e;
    stim.delete();
    add(3'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    add(3'd2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    foreach (stim[i]) begin
      rst_n = stim[i].rst; bus.op = stim[i].op; bus.mem_ready = stim[i].mr;
      e.st = stim[i].rst ? stim[i].st : 4'd0;
      e.o  = stim[i].rst ? exp_outs(stim[i].st, stim[i].mr, stim[i].ill, stim[i].to) : '0;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (bus.state !== e.st || dut_outs() !== e.o) begin
        miscompares++;
        $display("FAIL reset[%0d] state=%0d outs=%b expected state=%0d outs=%b",
                 i, bus.state, dut_outs(), e.st, e.o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    exp_t e;
    stim.delete();
    add(3'd0, 1'b1, 4'd0); add(3'd0, 1'b1, 4'd1);
    add(3'd0, 1'b1, 4'd6); add(3'd0, 1'b1, 4'd7);
    foreach (stim[i]) begin
      rst_n = stim[i].rst; bus.op = stim[i].op; bus.mem_ready = stim[i].mr;
      e.st = stim[i].rst ? stim[i].st : 4'd0;
      e.o  = stim[i].rst ? exp_outs(stim[i].st, stim[i].mr, stim[i].ill, stim[i].to) : '0;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (bus.state !== e.st || dut_outs() !== e.o) begin
        miscompares++;
        $display("FAIL rtype[%0d] state=%0d outs=%b expected state=%0d outs=%b",
                 i, bus.state, dut_outs(), e.st, e.o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_stall();
    exp_t e;
    stim.delete();
    add(3'd1, 1'b1, 4'd0); add(3'd1, 1'b1, 4'd1); add(3'd1, 1'b1, 4'd2);
    for (int k = 0; k < 3; k++) add(3'd1, 1'b0, 4'd3);
    add(3'd1, 1'b1, 4'd3); add(3'd1, 1'b1, 4'd4);
    foreach (stim[i]) begin
      rst_n = stim[i].rst; bus.op = stim[i].op; bus.mem_ready = stim[i].mr;
      e.st = stim[i].rst ? stim[i].st : 4'd0;
      e.o  = stim[i].rst ? exp_outs(stim[i].st, stim[i].mr, stim[i].ill, stim[i].to) : '0;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (bus.state !== e.st || dut_outs() !== e.o) begin
        miscompares++;
        $display("FAIL lw_stall[%0d] state=%0d outs=%b expected state=%0d outs=%b",
                 i, bus.state, dut_outs(), e.st, e.o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump();
    exp_t e;
    stim.delete();
    add(3'd3, 1'b1, 4'd0); add(3'd3, 1'b1, 4'd1); add(3'd3, 1'b1, 4'd8);
    add(3'd5, 1'b1, 4'd0); add(3'd5, 1'b1, 4'd1); add(3'd5, 1'b1, 4'd9);
    foreach (stim[i]) begin
      rst_n = stim[i].rst; bus.op = stim[i].op; bus.mem_ready = stim[i].mr;
      e.st = stim[i].rst ? stim[i].st : 4'd0;
      e.o  = stim[i].rst ? exp_outs(stim[i].st, stim[i].mr, stim[i].ill, stim[i].to) : '0;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (bus.state !== e.st || dut_outs() !== e.o) begin
        miscompares++;
        $display("FAIL branch_jump[%0d] state=%0d outs=%b expected state=%0d outs=%b",
                 i, bus.state, dut_outs(), e.st, e.o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addi_sw();
    exp_t e;
    stim.delete();
    add(3'd4, 1'b1, 4'd0); add(3'd4, 1'b1, 4'd1); add(3'd4, 1'b1, 4'd10); add(3'd4, 1'b1, 4'd11);
    add(3'd2, 1'b1, 4'd0); add(3'd2, 1'b1, 4'd1); add(3'd2, 1'b1, 4'd2);  add(3'd2, 1'b1, 4'd5);
    foreach (stim[i]) begin
      rst_n = stim[i].rst; bus.op = stim[i].op; bus.mem_ready = stim[i].mr;
      e.st = stim[i].rst ? stim[i].st : 4'd0;
      e.o  = stim[i].rst ? exp_outs(stim[i].st, stim[i].mr, stim[i].ill, stim[i].to) : '0;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (bus.state !== e.st || dut_outs() !== e.o) begin
        miscompares++;
        $display("FAIL addi_sw[%0d] state=%0d outs=%b expected state=%0d outs=%b",
                 i, bus.state, dut_outs(), e.st, e.o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    stim.delete();
    add(3'd7, 1'b1, 4'd0); add(3'd7, 1'b1, 4'd1, 1'b1);
    add(3'd6, 1'b1, 4'd0); add(3'd6, 1'b1, 4'd1, 1'b1);
    add(3'd5, 1'b1, 4'd0); add(3'd5, 1'b1, 4'd1); add(3'd5, 1'b1, 4'd9);
    foreach (stim[i]) begin
      rst_n = stim[i].rst; bus.op = stim[i].op; bus.mem_ready = stim[i].mr;
      e.st = stim[i].rst ? stim[i].st : 4'd0;
      e.o  = stim[i].rst ? exp_outs(stim[i].st, stim[i].mr, stim[i].ill, stim[i].to) : '0;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (bus.state !== e.st || dut_outs() !== e.o) begin
        miscompares++;
        $display("FAIL illegal[%0d] state=%0d outs=%b expected state=%0d outs=%b",
                 i, bus.state, dut_outs(), e.st, e.o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    stim.delete();
    // sw stuck: 4th wait cycle aborts
    add(3'd2, 1'b1, 4'd0); add(3'd2, 1'b1, 4'd1); add(3'd2, 1'b1, 4'd2);
    for (int k = 0; k < 3; k++) add(3'd2, 1'b0, 4'd5);
    add(3'd2, 1'b0, 4'd5, 1'b0, 1'b1);
    // ready arrives exactly on the limit cycle: normal completion
    add(3'd2, 1'b1, 4'd0); add(3'd2, 1'b1, 4'd1); add(3'd2, 1'b1, 4'd2);
    for (int k = 0; k < 3; k++) add(3'd2, 1'b0, 4'd5);
    add(3'd2, 1'b1, 4'd5);
    // FETCH timeout re-enters FETCH with a fresh count
    for (int k = 0; k < 3; k++) add(3'd5, 1'b0, 4'd0);
    add(3'd5, 1'b0, 4'd0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) add(3'd5, 1'b0, 4'd0);
    add(3'd5, 1'b1, 4'd0); add(3'd5, 1'b1, 4'd1); add(3'd5, 1'b1, 4'd9);
    foreach (stim[i]) begin
      rst_n = stim[i].rst; bus.op = stim[i].op; bus.mem_ready = stim[i].mr;
      e.st = stim[i].rst ? stim[i].st : 4'd0;
      e.o  = stim[i].rst ? exp_outs(stim[i].st, stim[i].mr, stim[i].ill, stim[i].to) : '0;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (bus.state !== e.st || dut_outs() !== e.o) begin
        miscompares++;
        $display("FAIL timeout[%0d] state=%0d outs=%b expected state=%0d outs=%b",
                 i, bus.state, dut_outs(), e.st, e.o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    stim.delete();
    add(3'd2, 1'b1, 4'd0); add(3'd2, 1'b1, 4'd1); add(3'd2, 1'b1, 4'd2);
    add(3'd2, 1'b0, 4'd5);
    add(3'd2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(3'd2, 1'b0, 4'd0); add(3'd5, 1'b1, 4'd0); add(3'd5, 1'b1, 4'd1); add(3'd5, 1'b1, 4'd9);
    foreach (stim[i]) begin
      rst_n = stim[i].rst; bus.op = stim[i].op; bus.mem_ready = stim[i].mr;
      e.st = stim[i].rst ? stim[i].st : 4'd0;
      e.o  = stim[i].rst ? exp_outs(stim[i].st, stim[i].mr, stim[i].ill, stim[i].to) : '0;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (bus.state !== e.st || dut_outs() !== e.o) begin
        miscompares++;
        $display("FAIL reset_mid[%0d] state=%0d outs=%b expected state=%0d outs=%b",
                 i, bus.state, dut_outs(), e.st, e.o);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.op        = 3'd0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch_jump();
    test_addi_sw();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle control FSM for the 16-bit MIPS core; it replaces the single-cycle combinational decoder. It sequences each instruction through fetch, decode, execute, memory and write-back cycles. It drives datapath strobes and mux selects, and it stalls on a memory ready handshake. An optional wait-timeout aborts hung memory accesses.

## Interface
- `OP_WIDTH`, 3: opcode field width.
- `WAIT_LIMIT`, 15: max cycles spent waiting for `mem_ready` in a memory state; 0 disables the timeout.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: synchronous, active-low reset.
- `op  in  OP_WIDTH`: opcode from instruction register; stable from DECODE until instruction ends.
- `mem_ready  in  1`: memory completes current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemToReg`, `RegWrite`, `RegDst`, `ALUSrcA`  out  1 each: datapath strobes and selects.
- `ALUSrcB  out  2`: 00 reg B, 01 constant PC increment, 10 sign-ext imm, 11 shifted imm (branch target).
- `ALUOp  out  2`: 00 R-type (funct), 01 subtract, 11 add.
- `PCSource  out  2`: 00 ALU result, 01 ALUOut register, 10 jump target.
- `instr_done  out  1`: last cycle of an instruction.
- `illegal_op  out  1`: undefined opcode decoded.
- `mem_timeout  out  1`: memory wait aborted.
- `state  out  4`: current state, for debug.

## Operation
- Opcodes: 000 R-type, 001 lw, 010 sw, 011 beq, 100 addi, 101 j. All other codes are illegal.
- Moore outputs decode from the state register. Exception: `PCWrite`/`IRWrite` in FETCH are gated by `mem_ready`. Any output not listed for a state is 0.
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=11, `PCSource`=00; `IRWrite`=`PCWrite`=`mem_ready`. Stays until `mem_ready`, then goes to DECODE.
- DECODE: `ALUSrcB`=11, `ALUOp`=11. Next state by opcode:
  - lw, sw → MEM_ADDR
  - R-type → EXEC
  - beq → BRANCH
  - j → JUMP
  - addi → ADDI_EX
  - illegal → FETCH with `illegal_op`=1 this cycle.
- MEM_ADDR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=11 → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: `MemRead`=1, `IorD`=1; waits for `mem_ready` → MEM_WB.
- MEM_WB: `RegWrite`=1, `MemToReg`=1, `RegDst`=0, `instr_done` → FETCH.
- MEM_WR: `MemWrite`=1, `IorD`=1; waits for `mem_ready`, then `instr_done` → FETCH.
- EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=00 → ALU_WB.
- ALU_WB: `RegWrite`=1, `RegDst`=1, `instr_done` → FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01, `instr_done` → FETCH.
- JUMP: `PCWrite`=1, `PCSource`=10, `instr_done` → FETCH.
- ADDI_EX: as MEM_ADDR → ADDI_WB. ADDI_WB: `RegWrite`=1, `RegDst`=0, `MemToReg`=0, `instr_done` → FETCH.
- Wait counter:
  - Counts cycles in FETCH, MEM_RD and MEM_WR with `mem_ready`=0.
  - Clears on any state change.
  - If it reaches `WAIT_LIMIT` (≠0) while `mem_ready`=0: `mem_timeout`=1 for that cycle, no strobe gating changes, next state FETCH.
  - `mem_ready`=1 in the limit cycle wins over the timeout.
  - A FETCH timeout re-enters FETCH and restarts the count.

## Timing
- Reset: while `rst_n`=0 at a clock edge, state ← FETCH and counter ← 0.
- While `rst_n` is low, all outputs are forced to 0 combinationally and `state` reads FETCH (0).
- Reset mid-instruction abandons it with no write strobe in the following cycle.
- Cycle counts with `mem_ready` tied high:
  - beq, j: 3
  - R-type, sw, addi: 4
  - lw: 5
- Each cycle of `mem_ready`=0 in a memory state adds one cycle.
- `instr_done` is high for exactly one cycle per completed instruction; never on an illegal or aborted instruction.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - opcode constants
  - 4-bit state encodings: FETCH=0 … ADDI_WB=11
  - `ALUOp`, `ALUSrcB` and `PCSource` encodings (shared with the ALU control and datapath).
- One sub-module, `wait_timer`: parametrised saturating counter with clear, enable and `expired` output.

## Test plan
- Reset, then `mem_ready`=1, op=000 → states 0,1,6,7,0; `RegWrite`&`RegDst` in cycle 4; `instr_done` once.
- op=001, `mem_ready` low for 3 cycles in MEM_RD → lw takes 8 cycles; `MemToReg`=`RegWrite`=1 only in MEM_WB.
- op=011 → `PCWriteCond`=1, `ALUOp`=01, `PCSource`=01 in cycle 3; op=101 → `PCWrite`=1, `PCSource`=10.
- op=111 → `illegal_op` pulses in DECODE, return to FETCH, no `RegWrite`/`MemWrite`/`instr_done`.
- `WAIT_LIMIT`=4, sw with `mem_ready` stuck 0 → `mem_timeout` on 4th wait cycle, FETCH next; repeat with `mem_ready`=1 on the 4th cycle → normal completion, no timeout.
- `rst_n` low during MEM_WR → all outputs 0 immediately, FETCH after the edge, `MemWrite` not reasserted.
